// File: rtl/cpu_ctrl_pkg.sv
// Shared controller definitions: state encoding, opcodes, datapath select codes.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_VECTOR = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Per-state control word. gate_rdy marks the memory states whose write-type
    // strobes and retire wait for mem_ready; gate_zero lets the branch qualify pc_en.
    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
        logic       gate_rdy;
        logic       gate_zero;
    } ctrl_t;

    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_ALU;
                c.ir_write  = 1'b1;
                c.pc_en     = 1'b1;
                c.gate_rdy  = 1'b1;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                c.gate_rdy = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.retire    = 1'b1;
                c.gate_rdy  = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_BRANCH;
                c.pc_en     = 1'b1;
                c.gate_zero = 1'b1;
                c.retire    = 1'b1;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_JUMP: begin
                c.pc_src = PC_JUMP;
                c.pc_en  = 1'b1;
                c.retire = 1'b1;
            end
            S_TRAP: begin
                c.pc_src  = PC_VECTOR;
                c.pc_en   = 1'b1;
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and the CPU datapath.
// Latency: n/a (wires only). illegal_instr exists only with ILLEGAL_TRAP_EN.
// Backpressure: memory stalls arrive on mem_ready; no other flow control.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_retired;
    logic       mem_timeout;
    logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  opcode, funct, zero, mem_ready,
`ifdef ILLEGAL_TRAP_EN
        output illegal_instr,
`endif
        output pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_retired, mem_timeout, state_o
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
`ifdef ILLEGAL_TRAP_EN
        input  illegal_instr,
`endif
        input  pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_retired, mem_timeout, state_o
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating memory-wait counter with a sticky timeout flag.
// Latency: timeout is registered, visible the cycle after the count reaches MAX.
// Backpressure: none; clr wins over en, the count holds at all-ones.
module mem_wait_timer #(
    parameter int MAX   = 15,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count: clear on state change, otherwise count stalled cycles up to saturation.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en && (cnt != '1)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Count register and sticky flag; only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt >= LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore controller sequencing PC, memory, register file and ALU one step per cycle.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles plus memory stalls. Option: ILLEGAL_TRAP_EN.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; write strobes wait on it.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);
    import cpu_ctrl_pkg::*;

    state_t st;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   wr_ok;
    logic   br_ok;
    logic   timeout;
    logic   unused_funct;

    // funct is decoded by the ALU control unit, not here.
    assign unused_funct = &{1'b0, bus.funct};

    // Next-state dispatch; unused encodings fall back to FETCH.
    always_comb begin
        nxt = st;
        case (st)
            S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDI_EX;
                    OP_J:         nxt = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      nxt = S_TRAP;
`else
                    default:      nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (bus.mem_ready) nxt = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) nxt = S_FETCH;
            S_EXEC:    nxt = S_ALUWB;
            S_ADDI_EX: nxt = S_ADDI_WB;
            default:   nxt = S_FETCH;
        endcase
    end

    // State register with the control word precomputed for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= S_FETCH;
            ctrl_q <= decode_state(S_FETCH);
        end else begin
            st     <= nxt;
            ctrl_q <= decode_state(nxt);
        end
    end

    mem_wait_timer #(
        .MAX   (MEM_WAIT_MAX),
        .CNT_W (WAIT_CNT_W)
    ) u_wait (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (nxt != st),
        .en      (ctrl_q.gate_rdy & ~bus.mem_ready),
        .timeout (timeout)
    );

    // Reset gates every output directly so an in-flight strobe drops at once.
    assign wr_ok = ~ctrl_q.gate_rdy | bus.mem_ready;
    assign br_ok = ~ctrl_q.gate_zero | bus.zero;

    assign bus.pc_en         = reset & ctrl_q.pc_en & wr_ok & br_ok;
    assign bus.ir_write      = reset & ctrl_q.ir_write & wr_ok;
    assign bus.reg_write     = reset & ctrl_q.reg_write & wr_ok;
    assign bus.mem_write     = reset & ctrl_q.mem_write & wr_ok;
    assign bus.instr_retired = reset & ctrl_q.retire & wr_ok;
    assign bus.pc_src        = reset ? ctrl_q.pc_src : 2'b00;
    assign bus.iord          = reset & ctrl_q.iord;
    assign bus.mem_read      = reset & ctrl_q.mem_read;
    assign bus.reg_dst       = reset & ctrl_q.reg_dst;
    assign bus.mem_to_reg    = reset & ctrl_q.mem_to_reg;
    assign bus.alu_src_a     = reset & ctrl_q.alu_src_a;
    assign bus.alu_src_b     = reset ? ctrl_q.alu_src_b : 2'b00;
    assign bus.alu_op        = reset ? ctrl_q.alu_op : 2'b00;
    assign bus.mem_timeout   = timeout;
    assign bus.state_o       = st;

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_instr = reset & ctrl_q.illegal;
`else
    logic unused_trap;
    assign unused_trap = ctrl_q.illegal;
`endif
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle main controller that sequences the CPU datapath: program counter, unified instruction/data memory, register file and ALU. Replaces the single-cycle combinational decode with a Moore FSM that issues one datapath step per cycle. Stalls on a memory ready handshake and reports a retire pulse per instruction.

Parameters:
MEM_WAIT_MAX, 15, max cycles a memory state waits for mem_ready before mem_timeout is raised (1..255)
WAIT_CNT_W, 8, width of the wait counter; must hold MEM_WAIT_MAX

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
opcode  in  6  instr[31:26], read from IR
funct  in  6  instr[5:0], read from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed current read/write this cycle
pc_en  out  1  PC register write enable
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  write register select: 0 rt, 1 rd
mem_to_reg  out  1  writeback select: 0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 decode from funct
instr_retired  out  1  one-cycle pulse on the last cycle of each instruction
mem_timeout  out  1  sticky; set when a memory wait exceeds MEM_WAIT_MAX
state_o  out  4  current state encoding, for debug

Behaviour:
- reset low: state=FETCH, wait counter=0, mem_timeout=0. All outputs forced 0 regardless of state.
- Outputs are Moore decodes of the state register. Write-type strobes (pc_en, ir_write, reg_write, mem_write) in memory states are additionally qualified by mem_ready.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en are asserted only when mem_ready=1; then go to DECODE, else stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Dispatch on opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDI_EX
    - 000010 -> JUMP
    - other -> FETCH, no retire
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read=1, iord=1. On mem_ready go to MEMWB, else hold.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retire. Next FETCH.
  - MEMWR: mem_write=1, iord=1. On mem_ready retire and go to FETCH, else hold.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire. Next FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, retire. Next FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, retire. Next FETCH.
  - JUMP: pc_src=10, pc_en=1, retire. Next FETCH.
- Latency with zero wait states (mem_ready=1 on first cycle): lw 5 cycles, sw/R-type/addi 4, beq/j 3.
- Wait counter: clears on entry to FETCH, MEMRD or MEMWR. Increments each cycle the FSM holds in one of those states with mem_ready=0, saturating at 2^WAIT_CNT_W-1. When the count reaches MEM_WAIT_MAX, mem_timeout is set. The FSM keeps waiting; mem_timeout clears only on reset.
- instr_retired is high exactly one cycle per completed instruction. It is never asserted during reset or for an illegal opcode.
- Reset asserted mid-instruction: the FSM aborts immediately, no partial write completes after reset falls, and the FSM restarts at FETCH.
- mem_ready outside memory states is ignored.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an undefined opcode in DECODE goes to TRAP. TRAP sets pc_src=11 (exception vector) and pc_en=1, and drives an added output illegal_instr high for one cycle. Next FETCH.
- Undefined: undefined opcodes return to FETCH silently, as specified above. pc_src=11 is never produced and illegal_instr does not exist.

Decomposition:
- Package cpu_ctrl_pkg holds: the state enum (4-bit), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), and the alu_op and pc_src/alu_src_b encodings. The ALU control unit and the top level share it.
- One sub-module, mem_wait_timer: the saturating counter plus sticky timeout flag, with clear/enable inputs.

Test Plan:
- Reset low for 3 cycles, then release with mem_ready=1 and opcode=000000 -> all outputs 0 during reset. After release, state sequence is FETCH, DECODE, EXEC, ALUWB; reg_write=1 and reg_dst=1 in cycle 4; instr_retired pulses once.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, ir_write not re-asserted, MEMWB reg_write=1 with mem_to_reg=1, total 7 cycles.
- beq (000100) with zero=1, then with zero=0 -> 3 cycles each; pc_en=1 with pc_src=01 only when zero=1; retire pulses both times.
- mem_ready held low in FETCH for 20 cycles (MEM_WAIT_MAX=15) -> mem_timeout rises after the 15th wait cycle and stays high. Asserting mem_ready then completes the fetch.
- Reset pulled low during MEMWR with mem_ready=0 -> mem_write drops immediately. After release, state is FETCH and no retire occurs.
- opcode=111111 -> FETCH after DECODE, no retire. With ILLEGAL_TRAP_EN: TRAP state, pc_src=11, pc_en=1, illegal_instr pulses once.
